seq_reg_arbiter: RTL and testbench
==================================

SEQ_REG_ARBITER -- requirements
Module: seq_reg_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the shared register and of both write ports.
REQ-002 SHALL have parameter INIT, default 0, value loaded into the shared register on reset.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port ASYNCRESETN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester n presents a write.
REQ-006 SHALL have ports req0_data / req1_data  input  WIDTH  write value of requester n.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  write of requester n accepted this cycle.
REQ-008 SHALL have port clr  input  1  synchronous clear of the shared register to INIT.
REQ-009 SHALL have port O_a  output  WIDTH  current shared register value.
REQ-010 SHALL have port grant_id  output  1  index of the most recent accepted requester.
REQ-011 SHALL have port busy  output  1  high while the FSM is in an OWN state.

Function
REQ-012 Transfer on requester n = reqn_valid & reqn_ready in the same cycle; the register takes reqn_data at that rising edge; O_a shows it one cycle later.
REQ-013 With no transfer and no clr, the register SHALL hold its value.
REQ-014 ready SHALL be combinational from valid, clr, FSM state and priority pointer; at most one ready high per cycle.
REQ-015 clr high: both ready low; register loads INIT at the edge; priority pointer and FSM state unchanged.
REQ-016 FSM states IDLE, OWN0, OWN1; in IDLE only one valid -> that requester gets ready.
REQ-017 In IDLE with both valid, the requester selected by the priority pointer gets ready; the other waits.
REQ-018 After every transfer the pointer SHALL point to the other requester (round robin); no transfer -> pointer unchanged.
REQ-019 grant_id SHALL update to n at the edge ending a transfer by requester n; unchanged otherwise.
REQ-020 Requests are not dropped: a waiting requester with valid held gets ready within 2 cycles (lock disabled) when no clr occurs.
REQ-021 data and valid of a non-ready requester SHALL have no effect on any state.

Reset
REQ-022 ASYNCRESETN low SHALL immediately force: register = INIT (so O_a = INIT), state IDLE, pointer = requester 0, grant_id = 0, busy = 0.
REQ-023 Reset mid-lock or mid-transfer SHALL abandon the lock/transfer; no write completes on the edge while reset is low.
REQ-024 Reset deassertion SHALL take effect on the first rising CLK edge with ASYNCRESETN high.

Configuration
REQ-025 Macro SEQ_REG_ARB_LOCK_EN SHALL compile in inputs req0_lock / req1_lock (1 bit each).
REQ-026 With macro: transfer by n with reqn_lock=1 moves FSM to OWNn (busy=1); in OWNn only requester n can be ready.
REQ-027 With macro: OWNn returns to IDLE after a transfer by n with reqn_lock=0; OWNn persists while reqn_valid is low; clr does not release the lock.
REQ-028 Without macro: lock ports absent, FSM never leaves IDLE, busy tied 0.

Verification
REQ-029 Reset, then no requests for 5 cycles -> O_a=0x00, grant_id=0, busy=0, both ready low.
REQ-030 req0 valid with 0xA5 only -> req0_ready=1 same cycle; next cycle O_a=0xA5, grant_id=0.
REQ-031 Both valid held (req0 0x11, req1 0x22) for 4 cycles from reset -> accepted order 0,1,0,1; O_a 0x11,0x22,0x11,0x22.
REQ-032 clr=1 with both valid after O_a=0x33 -> both ready low; next cycle O_a=0x00; pointer unchanged.
REQ-033 LOCK_EN: req1 writes 0x44 with lock=1, then 3 cycles req0 valid -> req0_ready low, busy=1; req1 writes 0x55 lock=0 -> IDLE, req0 accepted next cycle.
REQ-034 Assert ASYNCRESETN low mid-cycle during OWN1 with O_a=0x55 -> O_a=0x00, busy=0 before next edge.

Source files
------------

// File: rtl/seq_reg_arbiter.sv
// rtl/seq_reg_arbiter.sv - two-requester round-robin arbiter for one shared register
// Optional lock/ownership feature: define SEQ_REG_ARB_LOCK_EN.
module seq_reg_arbiter #(
   parameter int              WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT = '0
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
`ifdef SEQ_REG_ARB_LOCK_EN
   input  logic             req0_lock,
   input  logic             req1_lock,
`endif
   input  logic             clr,
   output logic [WIDTH-1:0] O_a,
   output logic             grant_id,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t           state_q;
   logic             ptr_q;
   logic             grant_q;
   logic             busy_q;
   logic [WIDTH-1:0] reg_q;
   logic [WIDTH-1:0] reg_d;
   logic             lock0;
   logic             lock1;

`ifdef SEQ_REG_ARB_LOCK_EN
   assign lock0 = req0_lock;
   assign lock1 = req1_lock;
`else
   // Without locking the FSM can never leave IDLE, so busy stays low.
   assign lock0 = 1'b0;
   assign lock1 = 1'b0;
`endif

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!clr) begin
         case (state_q)
            OWN0: req0_ready = req0_valid;
            OWN1: req1_ready = req1_valid;
            default: begin
               if (req0_valid && req1_valid) begin
                  req0_ready = ~ptr_q;
                  req1_ready = ptr_q;
               end else begin
                  req0_ready = req0_valid;
                  req1_ready = req1_valid;
               end
            end
         endcase
      end
   end

   always_comb begin
      reg_d = reg_q;
      if (req0_ready)      reg_d = req0_data;
      else if (req1_ready) reg_d = req1_data;
      else if (clr)        reg_d = INIT;
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         grant_q <= 1'b0;
         busy_q  <= 1'b0;
         reg_q   <= INIT;
      end else begin
         reg_q <= reg_d;
         // A transfer both advances round robin and decides lock ownership.
         if (req0_ready) begin
            grant_q <= 1'b0;
            ptr_q   <= 1'b1;
            state_q <= lock0 ? OWN0 : IDLE;
            busy_q  <= lock0;
         end else if (req1_ready) begin
            grant_q <= 1'b1;
            ptr_q   <= 1'b0;
            state_q <= lock1 ? OWN1 : IDLE;
            busy_q  <= lock1;
         end
      end
   end

   assign O_a      = reg_q;
   assign grant_id = grant_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_seq_reg_arbiter.sv
// tb/tb_seq_reg_arbiter.sv - randomized bench for seq_reg_arbiter against a behavioural model
module tb_seq_reg_arbiter;

   logic       CLK = 1'b0;
   logic       ASYNCRESETN = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic       req0_ready, req1_ready;
   logic       clr = 1'b0;
   logic [7:0] O_a;
   logic       grant_id, busy;
   logic       l0 = 1'b0, l1 = 1'b0;

   int n_pass = 0;
   int n_total = 0;

   // Reference state: register value, next-favoured requester, last grant, owner (-1 = none)
   int m_reg, m_ptr, m_grant, m_owner;

   always #5 CLK = ~CLK;

   seq_reg_arbiter #(.WIDTH(8), .INIT(8'h00)) dut (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
`ifdef SEQ_REG_ARB_LOCK_EN
      .req0_lock(l0), .req1_lock(l1),
`endif
      .clr(clr), .O_a(O_a), .grant_id(grant_id), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_reg = 0; m_ptr = 0; m_grant = 0; m_owner = -1;
   endtask

   // One clock cycle: apply inputs, check outputs mid-cycle against the model, advance model, clock.
   task automatic step(input bit v0, input int d0, input bit v1, input int d1,
                       input bit c, input bit k0, input bit k1, input string tag);
      int e0, e1;
      req0_valid = v0; req0_data = 8'(d0);
      req1_valid = v1; req1_data = 8'(d1);
      clr = c; l0 = k0; l1 = k1;
      #3;
      e0 = 0; e1 = 0;
      if (!c) begin
         if (m_owner == 0) e0 = v0;
         else if (m_owner == 1) e1 = v1;
         else if (v0 && v1) begin
            if (m_ptr == 0) e0 = 1; else e1 = 1;
         end else begin
            e0 = v0; e1 = v1;
         end
      end
      chk({tag, ".ready0"}, 32'(req0_ready), 32'(e0));
      chk({tag, ".ready1"}, 32'(req1_ready), 32'(e1));
      chk({tag, ".O_a"},    32'(O_a),        32'(m_reg));
      chk({tag, ".grant"},  32'(grant_id),   32'(m_grant));
      chk({tag, ".busy"},   32'(busy),       32'(m_owner != -1));
      if (e0 != 0) begin
         m_reg = d0; m_grant = 0; m_ptr = 1; m_owner = k0 ? 0 : -1;
      end else if (e1 != 0) begin
         m_reg = d1; m_grant = 1; m_ptr = 0; m_owner = k1 ? 1 : -1;
      end else if (c) begin
         m_reg = 0;
      end
      @(posedge CLK); #1;
   endtask

   task automatic idle(input string tag);
      step(0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge CLK);
      #1 ASYNCRESETN = 1'b1;

      repeat (5) idle("rst_idle");

      step(1, 8'hA5, 0, 0, 0, 0, 0, "req0_only");
      idle("after_a5");
      chk("a5_value", 32'(O_a), 32'h0000_00A5);

      ASYNCRESETN = 1'b0; model_reset(); #2; ASYNCRESETN = 1'b1; #2;
      @(posedge CLK); #1;
      for (int i = 0; i < 4; i++) step(1, 8'h11, 1, 8'h22, 0, 0, 0, "both_rr");
      idle("rr_done");

      step(1, 8'h33, 0, 0, 0, 0, 0, "load33");
      step(1, 8'h66, 1, 8'h77, 1, 0, 0, "clr_both");
      idle("after_clr");
      step(1, 8'h66, 1, 8'h77, 0, 0, 0, "ptr_kept");

`ifdef SEQ_REG_ARB_LOCK_EN
      step(0, 0, 1, 8'h44, 0, 0, 1, "lock1");
      for (int i = 0; i < 3; i++) step(1, 8'h99, 0, 0, 0, 0, 0, "locked_wait");
      step(1, 8'h99, 1, 8'h55, 0, 0, 0, "unlock1");
      step(1, 8'h99, 0, 0, 0, 0, 0, "req0_after");
      step(0, 0, 1, 8'h55, 0, 0, 1, "relock1");
`else
      step(0, 0, 1, 8'h55, 0, 0, 0, "load55");
`endif
      // Asynchronous reset asserted mid-cycle must act before the next edge.
      req0_valid = 1'b1; req0_data = 8'hEE; req1_valid = 1'b1; req1_data = 8'hEE;
      #2 ASYNCRESETN = 1'b0;
      #1;
      chk("async_O_a",  32'(O_a),      32'h0);
      chk("async_busy", 32'(busy),     32'h0);
      chk("async_gnt",  32'(grant_id), 32'h0);
      @(posedge CLK); #1;
      chk("rst_edge_O_a", 32'(O_a), 32'h0);
      model_reset();
      ASYNCRESETN = 1'b1;

      for (int i = 0; i < 400; i++) begin
         bit v0, v1, c, k0, k1;
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         c  = ($urandom_range(0, 9) == 0);
`ifdef SEQ_REG_ARB_LOCK_EN
         k0 = ($urandom_range(0, 3) == 0);
         k1 = ($urandom_range(0, 3) == 0);
`else
         k0 = 1'b0; k1 = 1'b0;
`endif
         step(v0, int'($urandom_range(0, 255)), v1, int'($urandom_range(0, 255)),
              c, k0, k1, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
